mseq_code_scheduler: RTL

//  Round-robin scheduler sharing one 63-chip M-sequence generator among NREQ requesters.

---
 rtl/mseq_code_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mseq_code_scheduler.sv
// Round-robin scheduler sharing one 63-chip M-sequence generator among NREQ requesters.
// Optional idle watchdog in RUN enabled by defining MSEQ_SCHED_TIMEOUT_EN.
module mseq_code_scheduler #(
  parameter int NREQ    = 4,
  parameter int N       = 63,
  parameter int CODE_W  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic                     clkin,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*CODE_W-1:0]   req_code,
  output logic [NREQ-1:0]          grant,
  output logic                     rej,
  output logic                     busy,
  output logic                     chip_out,
  output logic                     chip_valid,
  output logic                     chip_last,
  output logic                     err,
  output logic [CODE_W-1:0]        gen_code,
  output logic                     gen_start,
  input  logic                     gen_bit,
  input  logic                     gen_valid
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;
  typedef struct packed {
    logic [IW-1:0]     idx;
    logic [CODE_W-1:0] code;
  } svc_t;

  state_t                     state, state_nx;
  svc_t                       svc, sel;
  logic [IW-1:0]              rr_ptr, ci;
  logic [CW-1:0]              cnt;
  logic [NREQ-1:0][CODE_W-1:0] codes;
  logic [NREQ-1:0]            code_ok;
  logic                       found, arb_en, sel_ok, sel_rej;
  logic                       chip_take, last_take, tmo;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign codes[i]   = req_code[i*CODE_W +: CODE_W];
    assign code_ok[i] = 32'(codes[i]) < N;
  end

  function automatic int wrap(input int v);
    return (v >= NREQ) ? v - NREQ : v;
  endfunction

  // First set request strictly after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    ci    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      ci = IW'(wrap(int'(rr_ptr) + k));
      if (!found && req[ci]) begin
        found    = 1'b1;
        sel.idx  = ci;
        sel.code = codes[ci];
      end
    end
  end

  // The cycle after a reject is a cooldown so the rejected requester can drop req.
  assign arb_en    = (state == IDLE) && !rej;
  assign sel_ok    = arb_en && found && code_ok[sel.idx];
  assign sel_rej   = arb_en && found && !code_ok[sel.idx];
  assign chip_take = (state == RUN) && gen_valid;
  assign last_take = chip_take && (cnt == CW'(N-1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sel_ok) state_nx = LAUNCH;
      LAUNCH:  state_nx = RUN;
      RUN:     if (last_take || tmo) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      svc        <= '0;
      rr_ptr     <= IW'(NREQ-1);
      cnt        <= '0;
      grant      <= '0;
      rej        <= 1'b0;
      chip_out   <= 1'b0;
      chip_valid <= 1'b0;
      chip_last  <= 1'b0;
    end else begin
      state      <= state_nx;
      rej        <= sel_rej;
      chip_valid <= chip_take;
      chip_out   <= chip_take & gen_bit;
      chip_last  <= last_take;
      if (sel_rej) rr_ptr <= sel.idx;
      if (sel_ok) begin
        svc   <= sel;
        grant <= NREQ'(1) << sel.idx;
      end
      if (state == LAUNCH)  cnt <= '0;
      else if (chip_take)   cnt <= cnt + CW'(1);
      if (state == DONE) begin
        grant  <= '0;
        rr_ptr <= svc.idx;
      end
    end
  end

  assign gen_code  = svc.code;
  assign gen_start = (state == LAUNCH);
  assign busy      = (state != IDLE);

`ifdef MSEQ_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;

  // idle_cnt holds the number of consecutive earlier RUN cycles without gen_valid.
  assign tmo = (state == RUN) && !gen_valid && (idle_cnt == TW'(TIMEOUT-1));

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= tmo;
      if (state != RUN || gen_valid) idle_cnt <= '0;
      else                           idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  // Watchdog absent: RUN waits indefinitely; the expression is a constant 0.
  assign tmo = (TIMEOUT < 0);
  assign err = 1'b0;
`endif

endmodule
